// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 game-key receiver: frame FSM states,
// Set-2 prefix bytes and the scan codes of the eight game keys.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_KEY_R = 8'h2D;
  localparam logic [7:0] SC_KEY_C = 8'h21;
  localparam logic [7:0] SC_KEY_1 = 8'h16;
  localparam logic [7:0] SC_KEY_2 = 8'h1E;
  localparam logic [7:0] SC_KEY_S = 8'h1B;
  localparam logic [7:0] SC_KEY_Z = 8'h1A;
  localparam logic [7:0] SC_KEY_X = 8'h22;
  localparam logic [7:0] SC_KEY_T = 8'h2C;

  // One-hot key select; bit order matches the key flag vector {t,x,z,s,2,1,c,r}.
  function automatic logic [7:0] key_mask(input logic [7:0] code);
    logic [7:0] m;
    m = '0;
    case (code)
      SC_KEY_R: m[0] = 1'b1;
      SC_KEY_C: m[1] = 1'b1;
      SC_KEY_1: m[2] = 1'b1;
      SC_KEY_2: m[3] = 1'b1;
      SC_KEY_S: m[4] = 1'b1;
      SC_KEY_Z: m[5] = 1'b1;
      SC_KEY_X: m[6] = 1'b1;
      SC_KEY_T: m[7] = 1'b1;
      default:  m    = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 pad conditioning: 2-flop synchronisers, a FILTER_LEN-deep deglitch
// filter on the clock line and a one-cycle falling-edge strobe.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall,
  output logic o_data
);

  logic [1:0]            clk_sync_q;
  logic [1:0]            data_sync_q;
  logic [FILTER_LEN-1:0] shift_q, shift_d;
  logic                  filt_q, filt_d;
  logic                  fall_q;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    shift_d = {shift_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_d  = filt_q;
    if (&shift_q) begin
      filt_d = 1'b1;
    end else if (~|shift_q) begin
      filt_d = 1'b0;
    end
  end

  // Idle PS/2 lines are high, so everything resets to ones to avoid a false edge.
  // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      shift_q     <= '1;
      filt_q      <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], i_ps2_clk};
      data_sync_q <= {data_sync_q[0], i_ps2_data};
      shift_q     <= shift_d;
      filt_q      <= filt_d;
      fall_q      <= filt_q & ~filt_d;
    end
  end

  assign o_fall = fall_q;
  assign o_data = data_sync_q[1];

endmodule

// File: rtl/ps2_keys.sv
// PS/2 device-to-host frame receiver with timeout, plus a Set-2 make/break
// decoder that holds level flags for the eight game keys.
module ps2_keys
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_key_r,
  output logic       o_key_c,
  output logic       o_key_1,
  output logic       o_key_2,
  output logic       o_key_s,
  output logic       o_key_z,
  output logic       o_key_x,
  output logic       o_key_t,
  output logic [7:0] o_code,
  output logic       o_code_valid,
  output logic       o_err
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic fall;
  logic sample;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_ps2_clk (i_ps2_clk),
    .i_ps2_data(i_ps2_data),
    .o_fall    (fall),
    .o_data    (sample)
  );

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [7:0]    keys_q, keys_d;
  logic [7:0]    hit;

  // Frame FSM and timeout; the FSM only moves on a filtered falling edge.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    tmo_d     = tmo_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (state_q == ST_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_LAST) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!sample) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d   = {sample, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = sample;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (sample && ((^shreg_q) ^ parity_q)) begin
            code_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  // Decoder acts on the byte while its valid strobe is high.
  always_comb begin
    keys_d = keys_q;
    brk_d  = brk_q;
    ext_d  = ext_q;
    hit    = key_mask(code_q);
    if (err_q) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (valid_q) begin
      if (code_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (code_q == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        if (!ext_q) begin
          keys_d = brk_q ? (keys_q & ~hit) : (keys_q | hit);
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      keys_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      keys_q    <= keys_d;
    end
  end

  assign {o_key_t, o_key_x, o_key_z, o_key_s,
          o_key_2, o_key_1, o_key_c, o_key_r} = keys_q;
  assign o_code       = code_q;
  assign o_code_valid = valid_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_ps2_keys.sv
// Self-checking bench for ps2_keys: directed scenarios plus random frames,
// compared against a scan-code level model of the keyboard state.
module tb_ps2_keys;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_r, key_c, key_1, key_2, key_s, key_z, key_x, key_t;
  logic [7:0] code;
  logic       code_valid, err;

  always #5 clk = ~clk;

  ps2_keys #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_key_r     (key_r),
    .o_key_c     (key_c),
    .o_key_1     (key_1),
    .o_key_2     (key_2),
    .o_key_s     (key_s),
    .o_key_z     (key_z),
    .o_key_x     (key_x),
    .o_key_t     (key_t),
    .o_code      (code),
    .o_code_valid(code_valid),
    .o_err       (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: key order r,c,1,2,s,z,x,t maps to flag bits 0..7.
  logic [7:0] key_codes [8] = '{8'h2D, 8'h21, 8'h16, 8'h1E, 8'h1B, 8'h1A, 8'h22, 8'h2C};
  logic [7:0] m_keys = '0;
  logic [7:0] m_code = '0;
  bit         m_brk = 1'b0;
  bit         m_ext = 1'b0;
  int         m_valid = 0;
  int         m_err = 0;

  // Pulse counters observed away from the active edge.
  int n_valid = 0;
  int n_err = 0;
  always @(negedge clk) begin
    if (code_valid === 1'b1) n_valid++;
    if (err === 1'b1) n_err++;
  end

  function automatic logic [7:0] keys_vec();
    return {key_t, key_x, key_z, key_s, key_2, key_1, key_c, key_r};
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_err++;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      m_valid++;
      m_code = b;
      if (b == 8'hF0) begin
        m_brk = 1'b1;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else begin
        if (!m_ext) begin
          for (int i = 0; i < 8; i++) begin
            if (key_codes[i] == b) m_keys[i] = !m_brk;
          end
        end
        m_brk = 1'b0;
        m_ext = 1'b0;
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device-side frame: data changes mid-high phase, host samples on falling edge.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits, input int half);
    logic [10:0] frame;
    frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      wait_cycles(half / 2);
      ps2_data = frame[i];
      wait_cycles(half - half / 2);
      ps2_clk = 1'b0;
      wait_cycles(half);
      ps2_clk = 1'b1;
    end
    wait_cycles(half / 2);
    ps2_data = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".code"}, 32'(code), 32'(m_code));
    check({tag, ".keys"}, 32'(keys_vec()), 32'(m_keys));
    check({tag, ".nvalid"}, n_valid, m_valid);
    check({tag, ".nerr"}, n_err, m_err);
  endtask

  task automatic frame_and_check(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                 input int half, input string tag);
    send_bits(b, bad_par, bad_stop, 11, half);
    wait_cycles(30);
    model_frame(b, !(bad_par || bad_stop));
    check_state(tag);
  endtask

  initial begin
    logic [7:0] b;
    int         sel;
    int         half;
    int         fault;

    wait_cycles(4);
    check("rst.keys", 32'(keys_vec()), 32'h0);
    check("rst.code", 32'(code), 32'h0);
    check("rst.valid", 32'(code_valid), 32'h0);
    check("rst.err", 32'(err), 32'h0);
    rst = 1'b0;
    wait_cycles(20);

    frame_and_check(8'h1B, 0, 0, 20, "make_s");

    frame_and_check(8'h1A, 0, 0, 20, "make_z");
    frame_and_check(8'h22, 0, 0, 16, "make_x");
    frame_and_check(8'hF0, 0, 0, 20, "brk_pfx");
    frame_and_check(8'h1A, 0, 0, 20, "brk_z");

    frame_and_check(8'hE0, 0, 0, 20, "ext_pfx");
    frame_and_check(8'h1A, 0, 0, 20, "ext_z");
    frame_and_check(8'h1A, 0, 0, 20, "plain_z");

    frame_and_check(8'h2D, 1, 0, 20, "bad_par");
    frame_and_check(8'h2D, 0, 1, 20, "bad_stop");

    // Short low pulses on the clock line must never reach the FSM.
    for (int i = 0; i < 6; i++) begin
      wait_cycles(15);
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
    end
    wait_cycles(30);
    check_state("glitch");
    frame_and_check(8'h22, 0, 0, 20, "post_glitch");

    // Start plus four data bits, then the clock stalls.
    send_bits(8'h5A, 0, 0, 5, 20);
    wait_cycles(TIMEOUT + 100);
    model_frame(8'h00, 0);
    check_state("timeout");
    frame_and_check(8'h21, 0, 0, 20, "post_tmo_c");

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 10);
      if (sel < 8) b = key_codes[sel];
      else if (sel == 8) b = 8'hF0;
      else if (sel == 9) b = 8'hE0;
      else b = 8'($urandom);
      half = $urandom_range(12, 30);
      fault = $urandom_range(0, 7);
      frame_and_check(b, fault == 0, fault == 1, half, $sformatf("rnd%0d", n));
    end

    // Flush any pending prefix, then hold key 1 before resetting mid-frame.
    frame_and_check(8'h00, 0, 0, 20, "flush");
    frame_and_check(8'h16, 0, 0, 20, "make_1");
    check("make_1.key1", 32'(key_1), 32'h1);
    send_bits(8'h1E, 0, 0, 6, 20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.keys", 32'(keys_vec()), 32'h0);
    check("arst.code", 32'(code), 32'h0);
    check("arst.valid", 32'(code_valid), 32'h0);
    check("arst.err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_keys = '0;
    m_code = '0;
    m_brk  = 1'b0;
    m_ext  = 1'b0;
    wait_cycles(20);
    frame_and_check(8'h1E, 0, 0, 20, "post_rst_2");
    check("post_rst_2.only", 32'(keys_vec()), 32'h08);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
